// File: rtl/mux.sv
// 4:1 lane multiplexer with a combinational output and an enable-gated registered copy.
// The registered path also reports when the captured select changes and counts those changes.
module mux #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*WIDTH-1:0]   i,
  input  logic [1:0]           s,
  input  logic                 en,
  output logic [WIDTH-1:0]     o,
  output logic [WIDTH-1:0]     o_q,
  output logic [1:0]           s_q,
  output logic                 sel_chg,
  output logic [CNT_W-1:0]     chg_cnt
);

  logic [WIDTH-1:0] lanes [4];
  logic [WIDTH-1:0] o_d;
  logic [1:0]       s_d;
  logic             sel_chg_d;
  logic [CNT_W-1:0] chg_cnt_d;

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign lanes[k] = i[k*WIDTH +: WIDTH];
  end

  always_comb begin
    o = lanes[s];
  end

  always_comb begin
    o_d       = o_q;
    s_d       = s_q;
    sel_chg_d = 1'b0;
    chg_cnt_d = chg_cnt;
    if (en) begin
      o_d       = lanes[s];
      s_d       = s;
      sel_chg_d = (s != s_q);
      // Count saturates rather than wrapping.
      if (sel_chg_d && (chg_cnt != {CNT_W{1'b1}})) begin
        chg_cnt_d = chg_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q     <= '0;
      s_q     <= 2'b00;
      sel_chg <= 1'b0;
      chg_cnt <= '0;
    end else begin
      o_q     <= o_d;
      s_q     <= s_d;
      sel_chg <= sel_chg_d;
      chg_cnt <= chg_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux.sv
// Randomized self-checking bench for mux: a wide instance (WIDTH=4, CNT_W=8) and a narrow
// instance (WIDTH=1, CNT_W=2) share select/enable/reset and are compared to a behavioural model.
module tb_mux;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  s = 2'b00;
  logic [15:0] i4 = '0;
  logic [3:0]  i1 = '0;

  logic [3:0]  o4, oq4;
  logic [1:0]  sq4;
  logic        chg4;
  logic [7:0]  cnt4;
  logic        o1, oq1;
  logic [1:0]  sq1;
  logic        chg1;
  logic [1:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = wide instance, 1 = narrow instance.
  int m_oq  [2];
  int m_sq  [2];
  int m_chg [2];
  int m_cnt [2];

  mux #(.WIDTH(4), .CNT_W(8)) dut_w (
    .clk(clk), .rst(rst), .i(i4), .s(s), .en(en),
    .o(o4), .o_q(oq4), .s_q(sq4), .sel_chg(chg4), .chg_cnt(cnt4)
  );

  mux #(.WIDTH(1), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .i(i1), .s(s), .en(en),
    .o(o1), .o_q(oq1), .s_q(sq1), .sel_chg(chg1), .chg_cnt(cnt1)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lane(input int w, input int data, input int sel);
    return (data >> (sel * w)) & ((1 << w) - 1);
  endfunction

  task automatic model_edge();
    int w, data, maxc;
    for (int k = 0; k < 2; k++) begin
      w    = (k == 0) ? 4 : 1;
      data = (k == 0) ? int'(i4) : int'(i1);
      maxc = (k == 0) ? 255 : 3;
      if (rst) begin
        m_oq[k] = 0; m_sq[k] = 0; m_chg[k] = 0; m_cnt[k] = 0;
      end else if (en) begin
        m_chg[k] = (int'(s) != m_sq[k]) ? 1 : 0;
        if (m_chg[k] == 1 && m_cnt[k] < maxc) m_cnt[k]++;
        m_oq[k] = lane(w, data, int'(s));
        m_sq[k] = int'(s);
      end else begin
        m_chg[k] = 0;
      end
    end
  endtask

  task automatic check_comb(input string tag);
    #1;
    check_eq({tag, ".o_w"}, 32'(o4), 32'(lane(4, int'(i4), int'(s))));
    check_eq({tag, ".o_n"}, 32'(o1), 32'(lane(1, int'(i1), int'(s))));
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".oq_w"},  32'(oq4),  32'(m_oq[0]));
    check_eq({tag, ".sq_w"},  32'(sq4),  32'(m_sq[0]));
    check_eq({tag, ".chg_w"}, 32'(chg4), 32'(m_chg[0]));
    check_eq({tag, ".cnt_w"}, 32'(cnt4), 32'(m_cnt[0]));
    check_eq({tag, ".oq_n"},  32'(oq1),  32'(m_oq[1]));
    check_eq({tag, ".sq_n"},  32'(sq1),  32'(m_sq[1]));
    check_eq({tag, ".chg_n"}, 32'(chg1), 32'(m_chg[1]));
    check_eq({tag, ".cnt_n"}, 32'(cnt1), 32'(m_cnt[1]));
  endtask

  // Apply inputs, check o before the edge, clock once, then check registered outputs.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] sel,
                      input logic [15:0] d4, input logic [3:0] d1);
    rst = r; en = e; s = sel; i4 = d4; i1 = d1;
    check_comb(tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
    // o must still reflect the lane after the edge, regardless of rst/en.
    check_eq({tag, ".o_post"}, 32'(o1), 32'(lane(1, int'(i1), int'(s))));
  endtask

  logic [3:0] sweep_i [5] = '{4'b0001, 4'b0011, 4'b0100, 4'b1000, 4'b1110};
  logic [1:0] sweep_s [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic       sweep_o [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    // Combinational sweep with the clock stopped.
    for (int k = 0; k < 5; k++) begin
      i1 = sweep_i[k]; s = sweep_s[k]; i4 = 16'(k * 16'h1357);
      #1;
      check_eq("sweep.o_n", 32'(o1), 32'(sweep_o[k]));
      check_eq("sweep.o_w", 32'(o4), 32'(lane(4, int'(i4), int'(s))));
    end

    clk_run = 1'b1;
    step("reset", 1'b1, 1'b0, 2'b10, 16'hffff, 4'hf);
    step("zero", 1'b0, 1'b1, 2'b00, 16'h0000, 4'h0);
    check_eq("zero.chg_direct", 32'(chg4), 32'd0);

    // Stepped select: three changes.
    step("walk1", 1'b0, 1'b1, 2'b01, 16'h1234, 4'b0010);
    step("walk2", 1'b0, 1'b1, 2'b10, 16'h5678, 4'b0100);
    step("walk3", 1'b0, 1'b1, 2'b11, 16'h9abc, 4'b1000);
    check_eq("walk.cnt_direct", 32'(cnt4), 32'd3);
    check_eq("walk.sq_direct", 32'(sq4), 32'd3);

    // Data change with stable select: no pulse.
    step("hold_s", 1'b0, 1'b1, 2'b11, 16'h0fed, 4'b0111);

    // Disabled: inputs move, registered path holds.
    step("dis1", 1'b0, 1'b0, 2'b00, 16'hbeef, 4'b0001);
    step("dis2", 1'b0, 1'b0, 2'b01, 16'hcafe, 4'b0010);

    // Saturation on the narrow instance.
    step("sat_rst", 1'b1, 1'b1, 2'b00, 16'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      step("sat", 1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b00, 16'(k * 16'h1111), 4'(k));
    end
    check_eq("sat.cnt_n_direct", 32'(cnt1), 32'd3);
    check_eq("sat.cnt_w_direct", 32'(cnt4), 32'd6);

    // First capture after reset with nonzero select pulses.
    step("rst2", 1'b1, 1'b1, 2'b10, 16'h4321, 4'b0100);
    step("first_nz", 1'b0, 1'b1, 2'b10, 16'h4321, 4'b0100);

    // Reset mid-sequence with en high.
    step("mid1", 1'b0, 1'b1, 2'b01, 16'h00f0, 4'b0010);
    step("mid_rst", 1'b1, 1'b1, 2'b11, 16'hf000, 4'b1000);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] rs;
      rs = ($urandom_range(0, 3) == 0) ? s : 2'($urandom);
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rs,
           16'($urandom), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
